// File: rtl/mem_copy_dma_if.sv
// mem_copy_dma_if: command, source-read, destination-write and status signals of the copy engine.
//   master modport: the copy engine (accepts commands, drives both memory ports and status).
//   slave modport : the environment (issues commands, serves reads, accepts writes).
interface mem_copy_dma_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int SRC_ADDR_WIDTH = 32,
    parameter int DST_ADDR_WIDTH = 26,
    parameter int LEN_WIDTH      = 16
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [SRC_ADDR_WIDTH-1:0] cmd_src_addr;
    logic [DST_ADDR_WIDTH-1:0] cmd_dst_addr;
    logic [LEN_WIDTH-1:0]      cmd_length;
    logic                      src_rd_en;
    logic [SRC_ADDR_WIDTH-1:0] src_rd_addr;
    logic [DATA_WIDTH-1:0]     src_rd_data;
    logic                      dst_wr_en;
    logic [DST_ADDR_WIDTH-1:0] dst_wr_addr;
    logic [DATA_WIDTH-1:0]     dst_wr_data;
    logic                      dst_wr_ready;
    logic                      busy;
    logic                      done;
    logic [LEN_WIDTH-1:0]      words_written;

    modport master (
        input  cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_length, src_rd_data, dst_wr_ready,
        output cmd_ready, src_rd_en, src_rd_addr, dst_wr_en, dst_wr_addr, dst_wr_data,
               busy, done, words_written
    );

    modport slave (
        output cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_length, src_rd_data, dst_wr_ready,
        input  cmd_ready, src_rd_en, src_rd_addr, dst_wr_en, dst_wr_addr, dst_wr_data,
               busy, done, words_written
    );
endinterface

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: single-channel block copy from host memory reads to controller memory writes.
//   clock   : sole clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : command (valid/ready, src/dst address, length), source read port (en/addr/data,
//             data one cycle after en), destination write port (en/addr/data/ready) and
//             status (busy, done pulse, words_written).
module mem_copy_dma #(
    parameter int DATA_WIDTH     = 8,
    parameter int SRC_ADDR_WIDTH = 32,
    parameter int DST_ADDR_WIDTH = 26,
    parameter int LEN_WIDTH      = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    mem_copy_dma_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    state_t                    state_q, state_d;
    logic [SRC_ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
    logic [DST_ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [LEN_WIDTH-1:0]      rd_rem_q, rd_rem_d;
    logic [LEN_WIDTH-1:0]      wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [AW:0]               count_q, count_d;
    logic [AW:0]               occ;
    logic                      inflight_q;
    logic [DATA_WIDTH-1:0]     fifo_q [FIFO_DEPTH];
    logic                      active, issue, push, pop;

    always_comb begin
        active     = (state_q == READ) || (state_q == DRAIN);
        // An issued read occupies a FIFO slot until its data lands, so it counts toward the limit.
        occ        = count_q + (AW+1)'(inflight_q);
        issue      = (state_q == READ) && (rd_rem_q != '0) && (occ < DEPTH_C);
        push       = inflight_q;
        pop        = active && (count_q != '0) && bus.dst_wr_ready;
        state_d    = state_q;
        src_addr_d = src_addr_q + SRC_ADDR_WIDTH'(issue);
        dst_addr_d = dst_addr_q + DST_ADDR_WIDTH'(pop);
        len_d      = len_q;
        rd_rem_d   = rd_rem_q - LEN_WIDTH'(issue);
        wr_cnt_d   = wr_cnt_q + LEN_WIDTH'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                src_addr_d = bus.cmd_src_addr;
                dst_addr_d = bus.cmd_dst_addr;
                len_d      = bus.cmd_length;
                rd_rem_d   = bus.cmd_length;
                wr_cnt_d   = '0;
                state_d    = (bus.cmd_length == '0) ? DONE : READ;
            end
            READ:  state_d = (issue && rd_rem_q == LEN_WIDTH'(1)) ? DRAIN : READ;
            DRAIN: state_d = (pop && wr_cnt_q + LEN_WIDTH'(1) == len_q) ? DONE : DRAIN;
            DONE:  state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready     = (state_q == IDLE);
    assign bus.src_rd_en     = issue;
    assign bus.src_rd_addr   = src_addr_q;
    assign bus.dst_wr_en     = active && (count_q != '0);
    assign bus.dst_wr_addr   = dst_addr_q;
    assign bus.dst_wr_data   = fifo_q[rd_ptr_q];
    assign bus.busy          = active;
    assign bus.done          = (state_q == DONE);
    assign bus.words_written = wr_cnt_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            src_addr_q <= '0;
            dst_addr_q <= '0;
            len_q      <= '0;
            rd_rem_q   <= '0;
            wr_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_addr_q <= src_addr_d;
            dst_addr_q <= dst_addr_d;
            len_q      <= len_d;
            rd_rem_q   <= rd_rem_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= issue;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_ptr_q] <= bus.src_rd_data;
    end
endmodule
